// File: rtl/rule_cfg_sched_pkg.sv
// Shared definitions for the rule-write scheduler and the rule configuration
// blocks: rule layout, address fields, info-type codes and write encoding.
// Optional build macro: RULE_CFG_INVALIDATE_EN (adds the INVAL state).
package rule_cfg_sched_pkg;

    localparam int LAYER_W_DEF       = 4;
    localparam int TYPE_NUM          = 4;
    localparam int KEY_FILED_NUM     = 8;
    localparam int TYPE_WIDTH        = 16;
    localparam int TYPE_OFFSET_WIDTH = 8;
    localparam int KEY_OFFSET_WIDTH  = 8;
    localparam int SHIFT_WIDTH       = 8;

    // Rule-write address fields
    localparam int B_LAYER_MSB     = 15;
    localparam int B_LAYER_LSB     = 12;
    localparam int B_INFO_TYPE_MSB = 10;
    localparam int B_INFO_TYPE_LSB = 8;
    localparam int B_EXTR_ID_MSB   = 7;
    localparam int B_EXTR_ID_LSB   = 0;
    localparam int LAYER_FIELD_W   = B_LAYER_MSB - B_LAYER_LSB + 1;

    // Info-type codes
    localparam logic [2:0] INFO_VALID = 3'd0;
    localparam logic [2:0] INFO_TYPE  = 3'd1;
    localparam logic [2:0] INFO_TOFF  = 3'd2;
    localparam logic [2:0] INFO_KEY   = 3'd3;
    localparam logic [2:0] INFO_HEAD  = 3'd4;
    localparam logic [2:0] INFO_META  = 3'd5;

    // Item counter covers the longer of the TYPE and KEY phases
    localparam int ITEM_MAX = (TYPE_NUM > KEY_FILED_NUM) ? TYPE_NUM : KEY_FILED_NUM;
    localparam int CNT_W    = (ITEM_MAX > 1) ? $clog2(ITEM_MAX) : 1;
    localparam int TIDX_W   = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
    localparam int KIDX_W   = (KEY_FILED_NUM > 1) ? $clog2(KEY_FILED_NUM) : 1;

    typedef struct packed {
        logic                                              typeRule_valid;
        logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]               typeData;
        logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]               typeMask;
        logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]        typeOffset;
        logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0]      keyOffset;
        logic [SHIFT_WIDTH-1:0]                            headShift;
        logic [SHIFT_WIDTH-1:0]                            metaShift;
    } type_rule_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_TYPE   = 4'd1,
        ST_TOFF   = 4'd2,
        ST_KEY    = 4'd3,
        ST_HEAD   = 4'd4,
        ST_META   = 4'd5,
        ST_COMMIT = 4'd6,
        ST_DONE   = 4'd7
`ifdef RULE_CFG_INVALIDATE_EN
        , ST_INVAL = 4'd8
`endif
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } write_t;

    // States that drive a rule write
    function automatic logic is_write_state(input state_e st);
        logic res;
        case (st)
            ST_IDLE, ST_DONE: res = 1'b0;
            default:          res = 1'b1;
        endcase
        return res;
    endfunction

    // Address/data of the write issued in state st for item cnt
    function automatic write_t rule_write(input state_e st, input logic [CNT_W-1:0] cnt,
                                          input logic [LAYER_FIELD_W-1:0] layer,
                                          input logic [7:0] rid, input logic del,
                                          input type_rule_t rule);
        write_t              wr;
        logic [TIDX_W-1:0]   ti;
        logic [KIDX_W-1:0]   ki;
        ti = cnt[TIDX_W-1:0];
        ki = cnt[KIDX_W-1:0];
        wr = '0;
        case (st)
`ifdef RULE_CFG_INVALIDATE_EN
            ST_INVAL: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_VALID;
                wr.addr[B_EXTR_ID_MSB:B_EXTR_ID_LSB]     = rid;
            end
`endif
            ST_TYPE: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_TYPE;
                wr.addr[B_EXTR_ID_MSB:B_EXTR_ID_LSB]     = 8'(cnt);
                wr.data[16 +: TYPE_WIDTH]                = rule.typeData[ti];
                wr.data[0 +: TYPE_WIDTH]                 = rule.typeMask[ti];
            end
            ST_TOFF: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_TOFF;
                wr.addr[B_EXTR_ID_MSB:B_EXTR_ID_LSB]     = 8'(cnt);
                wr.data[0 +: TYPE_OFFSET_WIDTH]          = rule.typeOffset[ti];
            end
            ST_KEY: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_KEY;
                wr.addr[B_EXTR_ID_MSB:B_EXTR_ID_LSB]     = 8'(cnt);
                wr.data[16]                              = rule.keyOffset[ki][KEY_OFFSET_WIDTH];
                wr.data[0 +: KEY_OFFSET_WIDTH]           = rule.keyOffset[ki][KEY_OFFSET_WIDTH-1:0];
            end
            ST_HEAD: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_HEAD;
                wr.data[0 +: SHIFT_WIDTH]                = rule.headShift;
            end
            ST_META: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_META;
                wr.data[0 +: SHIFT_WIDTH]                = rule.metaShift;
            end
            ST_COMMIT: begin
                wr.addr[B_INFO_TYPE_MSB:B_INFO_TYPE_LSB] = INFO_VALID;
                wr.addr[B_EXTR_ID_MSB:B_EXTR_ID_LSB]     = rid;
                wr.data[0]                               = del ? 1'b0 : rule.typeRule_valid;
            end
            default: wr = '0;
        endcase
        if (is_write_state(st)) begin
            wr.addr[B_LAYER_MSB:B_LAYER_LSB] = layer;
        end else begin
            wr.addr = 32'h0000_0000;
        end
        return wr;
    endfunction

endpackage

// File: rtl/rule_cfg_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, priority starts just
// after the last granted requester. i_en gates the grant.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx
);
    localparam int SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_SUM   = SUM_W'(N);
    localparam logic [N-1:0]     GNT_ONE = N'(1'b1);

    logic [IDX_W-1:0] r_ptr;
    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_inc;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_any;

    // Rotate requests so bit 0 is the current priority holder, pick first set
    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = w_dbl[r_ptr +: N];
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_off = w_rot[i] ? IDX_W'(i) : w_off;
        end
        w_any     = i_en & (|w_rot);
        w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
        w_idx     = (w_sum >= N_SUM) ? IDX_W'(w_sum - N_SUM) : w_sum[IDX_W-1:0];
        w_inc     = {1'b0, w_idx} + SUM_W'(1);
        w_ptr_nxt = (w_inc >= N_SUM) ? '0 : w_inc[IDX_W-1:0];
        o_gnt     = w_any ? (GNT_ONE << w_idx) : '0;
        o_gnt_idx = w_idx;
    end

    // Priority pointer moves past each granted requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end
endmodule

// File: rtl/rule_cfg_sched.sv
// Rule-write scheduler: arbitrates rule commands and serializes each one into
// field writes followed by the rule-valid write. Optional build macro
// RULE_CFG_INVALIDATE_EN adds a leading invalidate write on loads.
module rule_cfg_sched
    import rule_cfg_sched_pkg::*;
#(
    parameter int REQ_NUM = 2,
    parameter int LAYER_W = LAYER_W_DEF,
    localparam int ID_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [REQ_NUM-1:0]                i_req_valid,
    output logic [REQ_NUM-1:0]                o_req_ready,
    input  logic [REQ_NUM-1:0][LAYER_W-1:0]   i_req_layer,
    input  logic [REQ_NUM-1:0][7:0]           i_req_ruleId,
    input  logic [REQ_NUM-1:0]                i_req_del,
    input  type_rule_t [REQ_NUM-1:0]          i_req_rule,
    output logic                              o_rule_wren,
    output logic [31:0]                       o_rule_addr,
    output logic [31:0]                       o_rule_wdata,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [ID_W-1:0]                   o_done_id
);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TYPE_LAST = CNT_W'(TYPE_NUM - 1);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_FILED_NUM - 1);
`ifdef RULE_CFG_INVALIDATE_EN
    localparam state_e ST_LOAD_FIRST = ST_INVAL;
`else
    localparam state_e ST_LOAD_FIRST = ST_TYPE;
`endif

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [LAYER_W-1:0]  r_layer;
    logic [7:0]          r_rule_id;
    logic                r_del;
    type_rule_t          r_rule;
    logic [ID_W-1:0]     r_gnt_id;
    logic [REQ_NUM-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_accept;
    logic [LAYER_W-1:0]  w_src_layer;
    logic [7:0]          w_src_rid;
    logic                w_src_del;
    type_rule_t          w_src_rule;
    write_t              w_wr;
    logic                w_wr_nxt;

    rr_arbiter #(.N(REQ_NUM)) u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req_valid),
        .i_en      (r_state == ST_IDLE),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign o_req_ready = w_gnt;
    assign w_accept    = |w_gnt;

    // Command source: live inputs on the accept cycle, latched copy afterwards
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_src_layer = i_req_layer[w_gnt_idx];
            w_src_rid   = i_req_ruleId[w_gnt_idx];
            w_src_del   = i_req_del[w_gnt_idx];
            w_src_rule  = i_req_rule[w_gnt_idx];
        end else begin
            w_src_layer = r_layer;
            w_src_rid   = r_rule_id;
            w_src_del   = r_del;
            w_src_rule  = r_rule;
        end
    end

    // Sequencer next state; item counter restarts on every state entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = CNT_ZERO;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_src_del ? ST_COMMIT : ST_LOAD_FIRST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef RULE_CFG_INVALIDATE_EN
            ST_INVAL: w_state_nxt = ST_TYPE;
`endif
            ST_TYPE: begin
                if (r_cnt == TYPE_LAST) begin
                    w_state_nxt = ST_TOFF;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_TOFF: begin
                if (r_cnt == TYPE_LAST) begin
                    w_state_nxt = ST_KEY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_KEY: begin
                if (r_cnt == KEY_LAST) begin
                    w_state_nxt = ST_HEAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_HEAD:   w_state_nxt = ST_META;
            ST_META:   w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr     = rule_write(w_state_nxt, w_cnt_nxt, LAYER_FIELD_W'(w_src_layer),
                                 w_src_rid, w_src_del, w_src_rule);
    assign w_wr_nxt = is_write_state(w_state_nxt);

    // State, counter and latched command
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_layer   <= '0;
            r_rule_id <= 8'h00;
            r_del     <= 1'b0;
            r_rule    <= '0;
            r_gnt_id  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_layer   <= w_src_layer;
                r_rule_id <= w_src_rid;
                r_del     <= w_src_del;
                r_rule    <= w_src_rule;
                r_gnt_id  <= w_gnt_idx;
            end
        end
    end

    // Registered write stream and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rule_wren  <= 1'b0;
            o_rule_addr  <= 32'h0000_0000;
            o_rule_wdata <= 32'h0000_0000;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_done_id    <= '0;
        end else begin
            o_rule_wren  <= w_wr_nxt;
            o_rule_addr  <= w_wr.addr;
            o_rule_wdata <= w_wr.data;
            o_busy       <= w_wr_nxt;
            o_done       <= (w_state_nxt == ST_DONE);
            o_done_id    <= (w_state_nxt == ST_DONE) ? r_gnt_id : '0;
        end
    end
endmodule
